// File: rtl/stream_mux_pkg.sv
//------------------------------------------------------------------------------
// stream_mux_pkg : shared modes and output-stage states for stream_mux_rr
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : stream_mux_pkg

`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : wrap-around priority search starting at ptr; first request wins
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int                 w_pos;
    logic [IDX_W-1:0]   w_pos_idx;
    grant     = '0;
    idx       = '0;
    any       = 1'b0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so one subtraction is enough to wrap
      w_pos = int'(ptr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_pos_idx = IDX_W'(w_pos);
      if (!any && req[w_pos_idx]) begin
        any              = 1'b1;
        grant[w_pos_idx] = 1'b1;
        idx              = w_pos_idx;
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/stream_mux_rr.sv
//------------------------------------------------------------------------------
// stream_mux_rr : N-input valid/ready stream mux, fixed or round-robin select,
//                 registered single-beat output stage
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 8,
  parameter int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_src
);

  localparam int              c_PAD_N = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N_IN - 1);

  state_e             r_state;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [SEL_W-1:0]   r_out_src;
  logic [SEL_W-1:0]   r_rr_ptr;

  logic [DATA_W-1:0]  w_ch_data [N_IN];
  logic [c_PAD_N-1:0] w_valid_pad;
  logic [c_PAD_N-1:0] w_sel_pad;
  logic [N_IN-1:0]    w_sel_oh;
  logic               w_fixed_win;
  logic [N_IN-1:0]    w_arb_grant;
  logic [SEL_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_win;
  logic [SEL_W-1:0]   w_gidx;
  logic [N_IN-1:0]    w_grant_oh;
  logic               w_load_en;
  logic               w_take;
  logic [DATA_W-1:0]  w_sel_data;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
      assign w_ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Padding to a power of two makes out-of-range sel read as "no request"
  always_comb begin
    w_valid_pad            = '0;
    w_valid_pad[N_IN-1:0]  = in_valid;
    w_sel_pad              = '0;
    w_sel_pad[sel]         = 1'b1;
  end

  assign w_sel_oh    = w_sel_pad[N_IN-1:0];
  assign w_fixed_win = w_valid_pad[sel];

  rr_arbiter #(
    .N     (N_IN),
    .IDX_W (SEL_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_rr_ptr),
    .grant (w_arb_grant),
    .idx   (w_arb_idx),
    .any   (w_arb_any)
  );

  assign w_win      = (mode == MODE_RR) ? w_arb_any   : w_fixed_win;
  assign w_gidx     = (mode == MODE_RR) ? w_arb_idx   : sel;
  assign w_grant_oh = (mode == MODE_RR) ? w_arb_grant : w_sel_oh;
  assign w_load_en  = (r_state == ST_EMPTY) | out_ready;
  assign w_take     = w_win & w_load_en & ~rst;
  assign in_ready   = w_take ? w_grant_oh : '0;
  assign w_sel_data = w_ch_data[w_gidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_take) begin
        r_out_data <= w_sel_data;
        r_out_src  <= w_gidx;
        if (mode == MODE_RR) begin
          r_rr_ptr <= (w_arb_idx == c_LAST) ? '0 : w_arb_idx + SEL_W'(1);
        end
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_take) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready && !w_take) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule : stream_mux_rr

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
//------------------------------------------------------------------------------
// tb_stream_mux_rr : directed and randomized checks against a queue-free model
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_mux_rr;

  localparam int N  = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [2:0]    sel;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_src;
  logic [DW-1:0] ch_data [N];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_pack
      assign in_data[g*DW +: DW] = ch_data[g];
    end
  endgenerate

  stream_mux_rr #(.DATA_W(DW), .N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  function automatic int winner();
    if (mode == 1'b0) begin
      return in_valid[sel] ? int'(sel) : -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = winner();
    if (rst || w < 0 || (m_valid && !out_ready)) return '0;
    return N'(1) << w;
  endfunction

  task automatic model_step();
    int w;
    w = winner();
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = ch_data[w];
        m_src   = w;
        if (mode) m_ptr = (w + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pattern_data();
    for (int k = 0; k < N; k++) ch_data[k] = 32'hA000_0000 | DW'(k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    pattern_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
        errors++; $display("FAIL reset_in_ready got=%h exp=00", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 3'd0) begin
        errors++;
        $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_src);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++; $display("FAIL reset_first_ready got=%h exp=01", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL reset_first_beat got v=%b d=%h s=%0d exp v=1 d=a0000000 s=0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (in_ready !== 8'h20) begin
        errors++; $display("FAIL fixed_ready cyc=%0d got=%h exp=20", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd5 || out_data !== 32'hA000_0005) begin
        errors++;
        $display("FAIL fixed_out cyc=%0d got v=%b d=%h s=%0d exp v=1 d=a0000005 s=5", c, out_valid, out_data, out_src);
      end
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (in_ready !== (8'h01 << (c % N))) begin
        errors++; $display("FAIL rr_ready cyc=%0d got=%h exp=%h", c, in_ready, 8'h01 << (c % N));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_src) != c % N || out_data !== (32'hA000_0000 | DW'(c % N))) begin
        errors++;
        $display("FAIL rr_seq cyc=%0d got v=%b s=%0d d=%h exp s=%0d", c, out_valid, out_src, out_data, c % N);
      end
    end
  endtask

  task automatic test_sparse_rr();
    int exp_src [3] = '{7, 1, 7};
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    tick();
    in_valid = 8'b1000_0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_src) != exp_src[c]) begin
        errors++;
        $display("FAIL sparse_rr step=%0d got v=%b s=%0d exp s=%0d", c, out_valid, out_src, exp_src[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
    ch_data[3] = 32'hDEAD_BEEF;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 8'($urandom) | 8'h01;
      sel      = 3'($urandom);
      mode     = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
        errors++; $display("FAIL bp_ready cyc=%0d got=%h exp=00", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d exp v=1 d=deadbeef s=3", c, out_valid, out_data, out_src);
      end
    end
    mode = 1'b0; sel = 3'd6; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h40) begin
      errors++; $display("FAIL bp_release_ready got=%h exp=40", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd6 || out_data !== 32'hA000_0006) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%h s=%0d exp v=1 d=a0000006 s=6", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_reset_mid();
    pattern_data();
    mode = 1'b1; in_valid = 8'h10; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 8'hFF;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h00) begin
      errors++; $display("FAIL midrst_ready got=%h exp=00", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL midrst_ptr got v=%b s=%0d d=%h exp v=1 s=0 d=a0000000", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      in_valid  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < N; k++) ch_data[k] = $urandom;
      #1;
      er = exp_ready();
      checks++;
      if (in_ready !== er) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%h exp=%h", c, in_ready, er);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_src) != m_src))) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_sparse_rr();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stream_mux_rr

`default_nettype wire
